// File: rtl/pu_sequencer.sv
// pu_sequencer: issues one neuron per cycle to a fixed-latency PU, tracks each
// issue through a {valid, idx} pipe matching the PU latency, and registers every
// PU result with its neuron index. done pulses with the last result.
module pu_sequencer #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2,
  parameter int PU_LAT      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic [31:0]      pu_out,
  output logic [IDX_W-1:0] w_addr,
  output logic             issue_valid,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_idx,
  output logic [31:0]      res_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               cnt_q, cnt_d;
  logic [PU_LAT-1:0]              pipe_vld_q, pipe_vld_d;
  logic [PU_LAT-1:0][IDX_W-1:0]   pipe_idx_q, pipe_idx_d;
  logic                           res_valid_q, res_valid_d;
  logic [IDX_W-1:0]               res_idx_q, res_idx_d;
  logic [31:0]                    res_data_q, res_data_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           tail_vld_s;
  logic [IDX_W-1:0]               tail_idx_s;

  assign tail_vld_s = pipe_vld_q[PU_LAT-1];
  assign tail_idx_s = pipe_idx_q[PU_LAT-1];

  // Next-state, issue counter and combinational issue strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    issue_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        issue_valid = !hold;
        if (!hold) begin
          if (cnt_q == LAST_IDX) begin
            // Last neuron issued: park the counter at 0 and wait for results.
            state_d = DRAIN;
            cnt_d   = {IDX_W{1'b0}};
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DRAIN: begin
        // Leave only after the final result has been presented for a cycle.
        if (done_q) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Tracking pipe shift and result capture from the pipe tail.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_idx_d    = pipe_idx_q;
    pipe_vld_d[0] = issue_valid;
    pipe_idx_d[0] = cnt_q;
    for (int i = 1; i < PU_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
    res_valid_d = tail_vld_s;
    if (tail_vld_s) begin
      res_data_d = pu_out;
      res_idx_d  = tail_idx_s;
    end else begin
      res_data_d = res_data_q;
      res_idx_d  = res_idx_q;
    end
    done_d = tail_vld_s && (tail_idx_s == LAST_IDX) && (state_q == DRAIN);
    busy_d = (state_d != IDLE) || done_d;
  end

  // State and datapath registers; reset discards all in-flight work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {IDX_W{1'b0}};
      pipe_vld_q  <= {PU_LAT{1'b0}};
      pipe_idx_q  <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= {IDX_W{1'b0}};
      res_data_q  <= 32'h0000_0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_idx_q  <= pipe_idx_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign w_addr    = cnt_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pu_sequencer.sv
// Directed bench for pu_sequencer: two instances (N=4/LAT=2 and N=1/LAT=3),
// each fed by a PU stand-in returning 32'h100+w_addr after PU_LAT edges.
// Expected per-cycle outputs are hand-listed per scenario.
module tb_pu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        hold;

  logic [31:0] pu_out0, pu_out1;
  logic [1:0]  w_addr0, res_idx0;
  logic [0:0]  w_addr1, res_idx1;
  logic        iv0, rv0, busy0, done0;
  logic        iv1, rv1, busy1, done1;
  logic [31:0] rd0, rd1;

  logic [31:0] pu0_p [0:1];
  logic [31:0] pu1_p [0:2];

  int n_checks;
  int n_errors;
  int cur_cyc;
  int scn;

  int exp_iv   [0:19];
  int exp_wa   [0:19];
  int exp_rv   [0:19];
  int exp_idx  [0:19];
  int exp_done [0:19];
  int exp_busy [0:19];

  pu_sequencer #(.NUM_NEURONS(4), .IDX_W(2), .PU_LAT(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .pu_out(pu_out0),
    .w_addr(w_addr0), .issue_valid(iv0), .res_valid(rv0), .res_idx(res_idx0),
    .res_data(rd0), .busy(busy0), .done(done0)
  );

  pu_sequencer #(.NUM_NEURONS(1), .IDX_W(1), .PU_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .pu_out(pu_out1),
    .w_addr(w_addr1), .issue_valid(iv1), .res_valid(rv1), .res_idx(res_idx1),
    .res_data(rd1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PU stand-ins: fixed-latency delay of 32'h100 + w_addr.
  always @(posedge clk) begin
    pu0_p[0] <= 32'h0000_0100 + 32'(w_addr0);
    pu0_p[1] <= pu0_p[0];
    pu1_p[0] <= 32'h0000_0100 + 32'(w_addr1);
    pu1_p[1] <= pu1_p[0];
    pu1_p[2] <= pu1_p[1];
  end
  assign pu_out0 = pu0_p[1];
  assign pu_out1 = pu1_p[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (scenario %0d cycle %0d): got 0x%0h expected 0x%0h", tag, scn, cur_cyc, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 20; i++) begin
      exp_iv[i] = 0; exp_wa[i] = 0; exp_rv[i] = 0;
      exp_idx[i] = 0; exp_done[i] = 0; exp_busy[i] = 0;
    end
  endtask

  task automatic mark_issue(input int c, input int k);
    exp_iv[c] = 1; exp_wa[c] = k;
  endtask

  task automatic mark_res(input int c, input int k);
    exp_rv[c] = 1; exp_idx[c] = k;
  endtask

  task automatic mark_busy(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_busy[i] = 1;
  endtask

  // Reset both instances and confirm every output is cleared.
  task automatic do_reset();
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    cur_cyc = -1;
    check_eq("rst_iv0",   32'(iv0),      32'd0);
    check_eq("rst_wa0",   32'(w_addr0),  32'd0);
    check_eq("rst_rv0",   32'(rv0),      32'd0);
    check_eq("rst_idx0",  32'(res_idx0), 32'd0);
    check_eq("rst_data0", rd0,           32'd0);
    check_eq("rst_busy0", 32'(busy0),    32'd0);
    check_eq("rst_done0", 32'(done0),    32'd0);
    check_eq("rst_busy1", 32'(busy1),    32'd0);
    check_eq("rst_rv1",   32'(rv1),      32'd0);
    rst = 1'b1;
  endtask

  function automatic logic f_start(input int c);
    case (scn)
      3:       f_start = (c <= 15);
      4:       f_start = (c == 0) || (c == 8);
      default: f_start = (c == 0);
    endcase
  endfunction

  function automatic logic f_hold(input int c);
    f_hold = (scn == 2) && (c >= 2) && (c <= 3);
  endfunction

  function automatic logic f_rst(input int c);
    f_rst = !((scn == 4) && (c == 5));
  endfunction

  // Drive one scenario cycle by cycle and compare against the expected tables.
  task automatic run_scn(input int sel, input int ncyc);
    logic        o_iv, o_rv, o_busy, o_done;
    logic [31:0] o_wa, o_idx, o_data;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      cur_cyc = c;
      start = f_start(c);
      hold  = f_hold(c);
      rst   = f_rst(c);
      #1;
      if (sel == 0) begin
        o_iv = iv0; o_rv = rv0; o_busy = busy0; o_done = done0;
        o_wa = 32'(w_addr0); o_idx = 32'(res_idx0); o_data = rd0;
      end else begin
        o_iv = iv1; o_rv = rv1; o_busy = busy1; o_done = done1;
        o_wa = 32'(w_addr1); o_idx = 32'(res_idx1); o_data = rd1;
      end
      check_eq("issue_valid", 32'(o_iv),   32'(exp_iv[c]));
      check_eq("res_valid",   32'(o_rv),   32'(exp_rv[c]));
      check_eq("busy",        32'(o_busy), 32'(exp_busy[c]));
      check_eq("done",        32'(o_done), 32'(exp_done[c]));
      if (exp_iv[c] != 0) check_eq("w_addr", o_wa, 32'(exp_wa[c]));
      if (exp_rv[c] != 0) begin
        check_eq("res_idx",  o_idx,  32'(exp_idx[c]));
        check_eq("res_data", o_data, 32'h0000_0100 + 32'(exp_idx[c]));
      end
      if (scn == 4 && c == 5) begin
        check_eq("midrst_wa",   o_wa,   32'd0);
        check_eq("midrst_idx",  o_idx,  32'd0);
        check_eq("midrst_data", o_data, 32'd0);
      end
    end
    start = 1'b0; hold = 1'b0; rst = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cur_cyc = 0; scn = 0;
    rst = 1'b0; start = 1'b0; hold = 1'b0;

    // 1: basic run, N=4, PU_LAT=2.
    scn = 1; do_reset(); clear_exp();
    for (int k = 0; k < 4; k++) begin
      mark_issue(1 + k, k);
      mark_res(4 + k, k);
    end
    exp_done[7] = 1; mark_busy(1, 7);
    run_scn(0, 10);

    // 2: hold during cycles 2-3.
    scn = 2; do_reset(); clear_exp();
    mark_issue(1, 0); mark_issue(4, 1); mark_issue(5, 2); mark_issue(6, 3);
    mark_res(4, 0);   mark_res(7, 1);   mark_res(8, 2);   mark_res(9, 3);
    exp_done[9] = 1; mark_busy(1, 9);
    run_scn(0, 12);

    // 3: start held high; second run sampled at cycle 8.
    scn = 3; do_reset(); clear_exp();
    for (int k = 0; k < 4; k++) begin
      mark_issue(1 + k, k);  mark_res(4 + k, k);
      mark_issue(9 + k, k);  mark_res(12 + k, k);
    end
    exp_done[7] = 1; exp_done[15] = 1;
    mark_busy(1, 7); mark_busy(9, 15);
    run_scn(0, 18);

    // 4: reset pulse at cycle 5, restart at cycle 8.
    scn = 4; do_reset(); clear_exp();
    for (int k = 0; k < 4; k++) begin
      mark_issue(1 + k, k);
      mark_issue(9 + k, k);  mark_res(12 + k, k);
    end
    mark_res(4, 0);
    exp_done[15] = 1;
    mark_busy(1, 4); mark_busy(9, 15);
    run_scn(0, 18);

    // 5: NUM_NEURONS=1, PU_LAT=3.
    scn = 5; do_reset(); clear_exp();
    mark_issue(1, 0); mark_res(5, 0);
    exp_done[5] = 1; mark_busy(1, 5);
    run_scn(1, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pu_sequencer.md
# pu_sequencer

Controller that drives one PU instance (four multipliers feeding a registered adder tree, then activation) through a layer of NUM_NEURONS neurons. After a start pulse it issues one neuron per cycle by presenting a weight-row address to the weight store. It tracks each issued neuron through the fixed PU pipeline latency and registers every PU output with its neuron index. It pulses done together with the last result. It sits between the layer-level control FSM and the PU/weight memory, and owns all PU issue timing.

## Interface
- NUM_NEURONS, 4, neurons per layer run (≥1)
- IDX_W, 2, width of neuron index, ≥ clog2(NUM_NEURONS), ≥1
- PU_LAT, 2, clock edges from PU inputs valid to PU `out` valid (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a layer run; sampled only in IDLE
- hold  input  1  pause issuing while in ISSUE; ignored in other states
- pu_out  input  32  PU `out` bus
- w_addr  output  IDX_W  neuron index whose a/w vectors feed the PU this cycle
- issue_valid  output  1  PU inputs valid this cycle (combinational)
- res_valid  output  1  res_data/res_idx hold a new result this cycle
- res_idx  output  IDX_W  neuron index of res_data
- res_data  output  32  registered PU result
- busy  output  1  run in progress
- done  output  1  one-cycle pulse, coincident with the final res_valid

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE
  - start=1 → ISSUE; issue counter cleared to 0.
  - start=0 → stay in IDLE.
- ISSUE
  - issue_valid = !hold.
  - w_addr = issue counter.
  - On each un-held cycle, the counter increments.
  - Issuing index NUM_NEURONS-1 → DRAIN.
  - hold=1 → issue_valid=0 and w_addr frozen. A hold inserts a bubble into the tracking pipe; it does not stall results already in flight.
- Tracking pipe: PU_LAT stages of {valid, idx}.
  - Stage 0 is loaded with {issue_valid, w_addr}; all stages shift every cycle.
  - When the tail stage is valid, pu_out is registered into res_data and the tail idx into res_idx, with res_valid=1 the next cycle.
- DRAIN
  - issue_valid=0.
  - When the registered result carries idx NUM_NEURONS-1: assert done, → IDLE.
- busy = (state ≠ IDLE) || done. It is registered and holds to the end of the run.
- start while busy is ignored, including in the done cycle. No queuing.
- Results appear strictly in index order, one per issue, never duplicated or dropped.
- The sequencer performs no arithmetic on pu_out; res_data is pu_out bit-exact.
- Counter wrap: the counter never exceeds NUM_NEURONS-1. NUM_NEURONS=1 → ISSUE lasts one un-held cycle.
- Reset (rst=0, any time, including mid-run):
  - state=IDLE; counter=0; pipe valid bits=0.
  - res_valid=0, res_idx=0, res_data=0, done=0, busy=0, issue_valid=0, w_addr=0.
  - In-flight results are discarded.

## Timing
- Cycle 0: start sampled. Cycle 1: first issue (w_addr=0).
- Result for an issue at cycle t: res_valid at cycle t+PU_LAT+1.
- With no hold: issues at cycles 1..N; results at cycles PU_LAT+2..N+PU_LAT+1; done at cycle N+PU_LAT+1; busy high cycles 1..N+PU_LAT+1.
- Each held cycle delays all later issues, results and done by exactly 1 cycle.
- Earliest restart: start sampled the cycle after done.
- All outputs except issue_valid are registered. issue_valid depends combinationally on state and hold only.

## Test plan
- Bench PU stand-in: returns 32'h100+w_addr, delayed PU_LAT edges.
- Basic run, N=4, PU_LAT=2, start at cycle 0, hold=0 → w_addr 0,1,2,3 with issue_valid at cycles 1–4; res_valid cycles 4–7 with res_data 0x100..0x103 and res_idx 0..3; done only at cycle 7; busy cycles 1–7.
- Hold=1 during cycles 2–3 → issues at cycles 1,4,5,6; results at cycles 4,7,8,9; res_valid=0 at cycles 5–6; done at cycle 9; indices still 0..3 in order.
- start held high continuously → second run's first issue at cycle 9 (start sampled cycle 8); no issue between cycles 5 and 8; exactly one done per run.
- Reset pulse at cycle 5 of a basic run → all outputs 0 immediately (async); no res_valid afterwards; a new start at cycle 8 runs cleanly with results 0x100..0x103.
- NUM_NEURONS=1, PU_LAT=3 → single issue at cycle 1; res_valid, res_idx=0, res_data=0x100 and done all at cycle 5; busy cycles 1–5.
